// File: rtl/ps2_move_decoder_if.sv
// Move-command handshake between the PS/2 decoder (master) and the game core (slave).
interface ps2_move_decoder_if;
  logic [2:0] move;
  logic       move_valid;
  logic       move_ready;

  modport master (output move, output move_valid, input  move_ready);
  modport slave  (input  move, input  move_valid, output move_ready);
endinterface

// File: rtl/ps2_move_decoder.sv
// Assembles PS/2 set-2 bytes into make/break events and queues direction-key
// presses as move commands in a 2-entry FIFO.
module ps2_move_decoder #(
  parameter int PREFIX_TIMEOUT = 1000000,
  parameter bit ENABLE_WASD    = 1'b1,
  parameter bit REPEAT_MOVES   = 1'b0
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [7:0]                 key_data,
  input  logic                       key_en,
  output logic [7:0]                 keycode,
  output logic                       key_make,
  output logic                       key_ext,
  output logic                       code_valid,
  ps2_move_decoder_if.master         mv,
  output logic [3:0]                 held,
  output logic                       overflow
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [19:0] TMO_LAST = 20'(PREFIX_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [19:0] tmo_q, tmo_d;
  logic [7:0]  keycode_q, keycode_d;
  logic        make_q, make_d, ext_q, ext_d, cv_q, cv_d;
  logic [3:0]  held_q, held_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]  fcnt_q, fcnt_d;

  logic        ev_valid, ev_make, ev_ext;
  logic [2:0]  dir;
  logic [1:0]  dir_idx;
  logic        push_req, push, pop;

  // 0 = not a direction key; otherwise 1 up, 2 down, 3 left, 4 right
  function automatic logic [2:0] dir_of(input logic [7:0] code, input logic ext);
    dir_of = 3'd0;
    if (ext) begin
      case (code)
        8'h75:   dir_of = 3'd1;
        8'h72:   dir_of = 3'd2;
        8'h6B:   dir_of = 3'd3;
        8'h74:   dir_of = 3'd4;
        default: dir_of = 3'd0;
      endcase
    end else if (ENABLE_WASD) begin
      case (code)
        8'h1D:   dir_of = 3'd1;
        8'h1B:   dir_of = 3'd2;
        8'h1C:   dir_of = 3'd3;
        8'h23:   dir_of = 3'd4;
        default: dir_of = 3'd0;
      endcase
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    tmo_d    = 20'd0;
    ev_valid = 1'b0;
    ev_make  = 1'b1;
    ev_ext   = 1'b0;
    case (state_q)
      IDLE: if (key_en) begin
        if (key_data == 8'hE0)      state_d = EXT;
        else if (key_data == 8'hF0) state_d = BRK;
        else                        ev_valid = 1'b1;
      end
      EXT: if (key_en) begin
        if (key_data == 8'hF0)      state_d = EXT_BRK;
        else if (key_data == 8'hE0) state_d = EXT;
        else begin
          ev_valid = 1'b1;
          ev_ext   = 1'b1;
          state_d  = IDLE;
        end
      end
      BRK: if (key_en && key_data != 8'hF0 && key_data != 8'hE0) begin
        ev_valid = 1'b1;
        ev_make  = 1'b0;
        state_d  = IDLE;
      end
      EXT_BRK: if (key_en && key_data != 8'hF0 && key_data != 8'hE0) begin
        ev_valid = 1'b1;
        ev_make  = 1'b0;
        ev_ext   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A stale prefix (lost byte) must not poison the next key
    if (state_q != IDLE && !key_en) begin
      if (tmo_q == TMO_LAST) state_d = IDLE;
      else                   tmo_d   = tmo_q + 20'd1;
    end
  end

  always_comb begin
    dir      = dir_of(key_data, ev_ext);
    dir_idx  = dir[1:0] - 2'd1;
    held_d   = held_q;
    push_req = 1'b0;
    if (ev_valid && dir != 3'd0) begin
      if (ev_make) begin
        if (!held_q[dir_idx] || REPEAT_MOVES) push_req = 1'b1;
        held_d[dir_idx] = 1'b1;
      end else begin
        held_d[dir_idx] = 1'b0;
      end
    end

    keycode_d = ev_valid ? key_data : keycode_q;
    make_d    = ev_valid ? ev_make  : make_q;
    ext_d     = ev_valid ? ev_ext   : ext_q;
    cv_d      = ev_valid;

    pop     = (fcnt_q != 2'd0) && mv.move_ready;
    push    = push_req && ((fcnt_q != 2'd2) || pop);
    ovf_d   = ovf_q | (push_req & ~push);
    fifo0_d = fifo0_q;
    fifo1_d = fifo1_q;
    fcnt_d  = fcnt_q;
    case ({push, pop})
      2'b01: begin
        fifo0_d = fifo1_q;
        fcnt_d  = fcnt_q - 2'd1;
      end
      2'b10: begin
        if (fcnt_q == 2'd0) fifo0_d = dir;
        else                fifo1_d = dir;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) fifo0_d = dir;
        else begin
          fifo0_d = fifo1_q;
          fifo1_d = dir;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      tmo_q     <= 20'd0;
      keycode_q <= 8'd0;
      make_q    <= 1'b0;
      ext_q     <= 1'b0;
      cv_q      <= 1'b0;
      held_q    <= 4'd0;
      ovf_q     <= 1'b0;
      fifo0_q   <= 3'd0;
      fifo1_q   <= 3'd0;
      fcnt_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      keycode_q <= keycode_d;
      make_q    <= make_d;
      ext_q     <= ext_d;
      cv_q      <= cv_d;
      held_q    <= held_d;
      ovf_q     <= ovf_d;
      fifo0_q   <= fifo0_d;
      fifo1_q   <= fifo1_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign keycode       = keycode_q;
  assign key_make      = make_q;
  assign key_ext       = ext_q;
  assign code_valid    = cv_q;
  assign held          = held_q;
  assign overflow      = ovf_q;
  assign mv.move_valid = (fcnt_q != 2'd0);
  assign mv.move       = (fcnt_q != 2'd0) ? fifo0_q : 3'd0;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench: two decoders (REPEAT_MOVES 0 and 1) fed the same byte stream.
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_ps2_move_decoder;
  localparam int TMO = 40;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] key_data = 8'd0;
  logic       key_en = 1'b0;

  logic [7:0] keycode0, keycode1;
  logic       make0, make1, ext0, ext1, cv0, cv1, ovf0, ovf1;
  logic [3:0] held0, held1;

  int checks = 0;
  int errors = 0;

  ps2_move_decoder_if if0 ();
  ps2_move_decoder_if if1 ();

  ps2_move_decoder #(.PREFIX_TIMEOUT(TMO), .ENABLE_WASD(1'b1), .REPEAT_MOVES(1'b0)) u0 (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_en(key_en),
    .keycode(keycode0), .key_make(make0), .key_ext(ext0), .code_valid(cv0),
    .mv(if0.master), .held(held0), .overflow(ovf0));

  ps2_move_decoder #(.PREFIX_TIMEOUT(TMO), .ENABLE_WASD(1'b1), .REPEAT_MOVES(1'b1)) u1 (
    .clock(clock), .resetn(resetn), .key_data(key_data), .key_en(key_en),
    .keycode(keycode1), .key_make(make1), .key_ext(ext1), .code_valid(cv1),
    .mv(if1.master), .held(held1), .overflow(ovf1));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (resetn) begin
      if (!if0.move_valid && (if0.move !== 3'd0)) begin
        errors++;
        $error("FAIL mon_move0_u0 observed=%0h expected=0", if0.move);
      end
      if (!if1.move_valid && (if1.move !== 3'd0)) begin
        errors++;
        $error("FAIL mon_move0_u1 observed=%0h expected=0", if1.move);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input logic [7:0] b);
    @(negedge clock);
    key_data = b;
    key_en   = 1'b1;
    @(negedge clock);
    key_en   = 1'b0;
  endtask

  task automatic pop(input logic p0, input logic p1);
    @(negedge clock);
    if0.move_ready = p0;
    if1.move_ready = p1;
    @(negedge clock);
    if0.move_ready = 1'b0;
    if1.move_ready = 1'b0;
  endtask

  initial begin
    if0.move_ready = 1'b0;
    if1.move_ready = 1'b0;
    repeat (3) @(negedge clock);
    `CHK("rst_keycode", keycode0, 8'h00);
    `CHK("rst_make", make0, 1'b0);
    `CHK("rst_ext", ext0, 1'b0);
    `CHK("rst_cv", cv0, 1'b0);
    `CHK("rst_move", if0.move, 3'd0);
    `CHK("rst_mvalid", if0.move_valid, 1'b0);
    `CHK("rst_held", held0, 4'h0);
    `CHK("rst_ovf", ovf0, 1'b0);
    resetn = 1'b1;

    // Extended up-arrow make
    send(8'hE0);
    `CHK("t1_cv_prefix", cv0, 1'b0);
    send(8'h75);
    `CHK("t1_keycode", keycode0, 8'h75);
    `CHK("t1_ext", ext0, 1'b1);
    `CHK("t1_make", make0, 1'b1);
    `CHK("t1_cv", cv0, 1'b1);
    `CHK("t1_move", if0.move, 3'd1);
    `CHK("t1_mvalid", if0.move_valid, 1'b1);
    `CHK("t1_held", held0, 4'b0001);
    @(negedge clock);
    `CHK("t1_cv_pulse", cv0, 1'b0);
    `CHK("t1_keycode_hold", keycode0, 8'h75);

    // Extended up-arrow break
    send(8'hE0); send(8'hF0); send(8'h75);
    `CHK("t2_make", make0, 1'b0);
    `CHK("t2_ext", ext0, 1'b1);
    `CHK("t2_cv", cv0, 1'b1);
    `CHK("t2_held", held0, 4'b0000);
    `CHK("t2_move", if0.move, 3'd1);
    pop(1'b1, 1'b1);
    `CHK("t2_empty", if0.move_valid, 1'b0);
    `CHK("t2_move0", if0.move, 3'd0);

    // Three arrow makes into a 2-entry FIFO
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    `CHK("t3_ovf_before", ovf0, 1'b0);
    send(8'hE0); send(8'h72);
    `CHK("t3_ovf", ovf0, 1'b1);
    `CHK("t3_held", held0, 4'b1110);
    `CHK("t3_head0", if0.move, 3'd3);
    pop(1'b1, 1'b1);
    `CHK("t3_head1", if0.move, 3'd4);
    `CHK("t3_valid1", if0.move_valid, 1'b1);
    pop(1'b1, 1'b1);
    `CHK("t3_empty", if0.move_valid, 1'b0);
    `CHK("t3_move0", if0.move, 3'd0);
    `CHK("t3_ovf_sticky", ovf0, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h72);
    `CHK("t3_held_clear", held0, 4'b0000);

    // Typematic repeats of W
    send(8'h1D);
    `CHK("t4_cv_a", cv0, 1'b1);
    send(8'h1D);
    `CHK("t4_cv_b", cv0, 1'b1);
    send(8'h1D);
    `CHK("t4_cv_c", cv0, 1'b1);
    `CHK("t4_keycode", keycode0, 8'h1D);
    `CHK("t4_r0_move", if0.move, 3'd1);
    `CHK("t4_r1_move", if1.move, 3'd1);
    pop(1'b1, 1'b1);
    `CHK("t4_r0_one", if0.move_valid, 1'b0);
    `CHK("t4_r1_second", if1.move, 3'd1);
    `CHK("t4_r1_valid", if1.move_valid, 1'b1);
    pop(1'b1, 1'b1);
    `CHK("t4_r1_drained", if1.move_valid, 1'b0);
    send(8'hF0); send(8'h1D);
    `CHK("t4_held_clear", held0, 4'b0000);
    `CHK("t4_break", make0, 1'b0);

    // Stale E0 prefix times out
    send(8'hE0);
    repeat (TMO + 5) @(negedge clock);
    send(8'h75);
    `CHK("t5_keycode", keycode0, 8'h75);
    `CHK("t5_ext", ext0, 1'b0);
    `CHK("t5_make", make0, 1'b1);
    `CHK("t5_nomove", if0.move_valid, 1'b0);
    `CHK("t5_held", held0, 4'b0000);

    // Prefixes inside a break are ignored; E1 is a plain code
    send(8'hF0); send(8'hE0); send(8'h75);
    `CHK("t5_brk_ext", ext0, 1'b0);
    `CHK("t5_brk_make", make0, 1'b0);
    send(8'hE1);
    `CHK("t5_e1_code", keycode0, 8'hE1);
    `CHK("t5_e1_nomove", if0.move_valid, 1'b0);

    // Reset in EXT_BRK, then fresh decode
    send(8'hE0); send(8'hF0);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    `CHK("t6_rst_ovf", ovf0, 1'b0);
    `CHK("t6_rst_valid", if1.move_valid, 1'b0);
    send(8'h1B);
    `CHK("t6_make", make0, 1'b1);
    `CHK("t6_ext", ext0, 1'b0);
    `CHK("t6_keycode", keycode0, 8'h1B);
    `CHK("t6_move", if0.move, 3'd2);
    `CHK("t6_held", held0, 4'b0010);

    // Fill, then push and pop together on a full FIFO (u0 only pops)
    send(8'h1C);
    @(negedge clock);
    key_data = 8'h23;
    key_en   = 1'b1;
    if0.move_ready = 1'b1;
    @(negedge clock);
    key_en   = 1'b0;
    if0.move_ready = 1'b0;
    `CHK("t6_pp_ovf", ovf0, 1'b0);
    `CHK("t6_pp_head", if0.move, 3'd3);
    `CHK("t6_r1_ovf", ovf1, 1'b1);
    `CHK("t6_r1_head", if1.move, 3'd2);
    pop(1'b1, 1'b0);
    `CHK("t6_pp_second", if0.move, 3'd4);
    pop(1'b1, 1'b0);
    `CHK("t6_pp_empty", if0.move_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end
endmodule
